// File: rtl/water_refill_controller.sv
// Inlet valve controller that refills the tank with hysteresis, waits for the dispenser
// to go idle, bounds each fill in time and latches a fault when the bound is exceeded.
module water_refill_controller #(
   parameter int unsigned LOW_MARK      = 4,
   parameter int unsigned HIGH_MARK     = 12,
   parameter int unsigned FILL_TIMEOUT  = 15,
   parameter int unsigned SETTLE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       refill_enable,
   input  logic [3:0] tank_level,
   input  logic       dispense_active,
   input  logic       fault_clear,
   output logic       inlet_valve,
   output logic       refill_active,
   output logic [3:0] fill_timer,
   output logic       refill_fault,
   output logic [7:0] refill_count
);

   localparam logic [3:0] LOW_LEVEL    = 4'(LOW_MARK);
   localparam logic [3:0] HIGH_LEVEL   = 4'(HIGH_MARK);
   localparam logic [3:0] TIMEOUT_LAST = 4'(FILL_TIMEOUT - 1);
   localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DISPENSE,
      FILLING,
      SETTLE,
      FAULT
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] fill_timer_reg, fill_timer_next;
   logic [3:0] settle_reg, settle_next;
   logic [7:0] count_reg, count_next;

   logic low_request;
   logic level_full;
   assign low_request = refill_enable && (tank_level <= LOW_LEVEL);
   assign level_full  = (tank_level >= HIGH_LEVEL);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         fill_timer_reg <= 4'd0;
         settle_reg     <= 4'd0;
         count_reg      <= 8'd0;
      end else begin
         state_reg      <= state_next;
         fill_timer_reg <= fill_timer_next;
         settle_reg     <= settle_next;
         count_reg      <= count_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      fill_timer_next = fill_timer_reg;
      settle_next     = settle_reg;
      count_next      = count_reg;
      case (state_reg)
         IDLE: begin
            fill_timer_next = 4'd0;
            settle_next     = 4'd0;
            if (low_request) begin
               state_next = dispense_active ? WAIT_DISPENSE : FILLING;
            end
         end
         WAIT_DISPENSE: begin
            if (!refill_enable) begin
               state_next = IDLE;
            end else if (!dispense_active) begin
               state_next      = FILLING;
               fill_timer_next = 4'd0;
            end
         end
         FILLING: begin
            // Abort outranks completion, completion outranks timeout.
            if (!refill_enable) begin
               state_next = IDLE;
            end else if (level_full) begin
               state_next  = SETTLE;
               settle_next = 4'd0;
            end else if (fill_timer_reg == TIMEOUT_LAST) begin
               state_next = FAULT;
            end else begin
               fill_timer_next = fill_timer_reg + 4'd1;
            end
         end
         SETTLE: begin
            // Enable is deliberately ignored: the fill has already completed.
            if (settle_reg == SETTLE_LAST) begin
               state_next = IDLE;
               count_next = count_reg + 8'd1;
            end else begin
               settle_next = settle_reg + 4'd1;
            end
         end
         FAULT: begin
            if (fault_clear) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign inlet_valve   = (state_reg == FILLING);
   assign refill_active = (state_reg == WAIT_DISPENSE) || (state_reg == FILLING) ||
                          (state_reg == SETTLE);
   assign refill_fault  = (state_reg == FAULT);
   assign fill_timer    = fill_timer_reg;
   assign refill_count  = count_reg;

endmodule

// File: tb/tb_water_refill_controller.sv
// Directed bench: each stimulus cycle queues its hand-computed expected outputs and a
// monitor compares them one time unit after the clock edge that produces them.
module tb_water_refill_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       refill_enable;
   logic [3:0] tank_level;
   logic       dispense_active;
   logic       fault_clear;
   logic       inlet_valve;
   logic       refill_active;
   logic [3:0] fill_timer;
   logic       refill_fault;
   logic [7:0] refill_count;

   water_refill_controller dut (
      .clk             (clk),
      .reset           (reset),
      .refill_enable   (refill_enable),
      .tank_level      (tank_level),
      .dispense_active (dispense_active),
      .fault_clear     (fault_clear),
      .inlet_valve     (inlet_valve),
      .refill_active   (refill_active),
      .fill_timer      (fill_timer),
      .refill_fault    (refill_fault),
      .refill_count    (refill_count)
   );

   always #5 clk = ~clk;

   logic [14:0] exp_q[$];
   string       tag_q[$];
   int          n_vec  = 0;
   int          n_fail = 0;
   logic [7:0]  cnt    = 8'd0;

   logic [14:0] mon_exp;
   logic [14:0] mon_act;
   string       mon_tag;

   function automatic logic [14:0] ex(input logic v, input logic a, input logic [3:0] t,
                                      input logic f, input logic [7:0] c);
      return {v, a, t, f, c};
   endfunction

   // Drive one cycle of inputs on the falling edge; optionally queue the outputs
   // expected right after the following rising edge.
   task automatic cyc(input logic r, input logic en, input logic [3:0] lvl, input logic da,
                      input logic fc, input bit chk, input logic [14:0] e, input string tag);
      @(negedge clk);
      reset           = r;
      refill_enable   = en;
      tank_level      = lvl;
      dispense_active = da;
      fault_clear     = fc;
      if (chk) begin
         exp_q.push_back(e);
         tag_q.push_back(tag);
      end
   endtask

   // Caller has already seen the SETTLE entry edge; two more settle cycles, then IDLE.
   task automatic settle_out(input logic [3:0] t, input bit chk);
      cyc(0, 1, 4'd13, 0, 0, chk, ex(0, 1, t, 0, cnt), "settle");
      cyc(0, 1, 4'd13, 0, 0, chk, ex(0, 1, t, 0, cnt), "settle");
      cnt = cnt + 8'd1;
      cyc(0, 1, 4'd13, 0, 0, chk, ex(0, 0, t, 0, cnt), "settle_done");
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_tag = tag_q.pop_front();
         mon_act = {inlet_valve, refill_active, fill_timer, refill_fault, refill_count};
         n_vec++;
         if (mon_act !== mon_exp) begin
            n_fail++;
            $display("FAIL %s: got valve=%0b active=%0b timer=%0d fault=%0b count=%0d, want valve=%0b active=%0b timer=%0d fault=%0b count=%0d",
                     mon_tag, mon_act[14], mon_act[13], mon_act[12:9], mon_act[8], mon_act[7:0],
                     mon_exp[14], mon_exp[13], mon_exp[12:9], mon_exp[8], mon_exp[7:0]);
         end else begin
            $display("ok   %s: valve=%0b active=%0b timer=%0d fault=%0b count=%0d",
                     mon_tag, mon_act[14], mon_act[13], mon_act[12:9], mon_act[8], mon_act[7:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      refill_enable   = 1'b0;
      tank_level      = 4'd8;
      dispense_active = 1'b0;
      fault_clear     = 1'b0;

      // Reset and release
      cyc(1, 0, 4'd8, 0, 0, 1, ex(0, 0, 0, 0, 0), "reset1");
      cyc(1, 0, 4'd8, 0, 0, 1, ex(0, 0, 0, 0, 0), "reset2");
      cyc(0, 0, 4'd8, 0, 0, 1, ex(0, 0, 0, 0, 0), "reset_release");

      // Normal fill: five increments, level 11 still fills, 12 completes
      cyc(0, 1, 4'd3, 0, 0, 1, ex(1, 1, 0, 0, cnt), "fill_start");
      for (int i = 1; i <= 5; i++) begin
         cyc(0, 1, (i == 5) ? 4'd11 : 4'd3, 0, 0, 1, ex(1, 1, 4'(i), 0, cnt), "fill_run");
      end
      cyc(0, 1, 4'd12, 0, 0, 1, ex(0, 1, 5, 0, cnt), "fill_high");
      settle_out(4'd5, 1);
      cyc(0, 1, 4'd12, 0, 0, 1, ex(0, 0, 0, 0, cnt), "idle_timer_clr");

      // Interlock with the dispenser
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 4'd2, 1, 0, 1, ex(0, 1, 0, 0, cnt), "wait_dispense");
      end
      cyc(0, 1, 4'd2, 0, 0, 1, ex(1, 1, 0, 0, cnt), "dispense_done_open");
      cyc(0, 1, 4'd2, 1, 0, 1, ex(1, 1, 1, 0, cnt), "dispense_ignored");
      cyc(0, 1, 4'd13, 1, 0, 1, ex(0, 1, 1, 0, cnt), "fill_high2");
      settle_out(4'd1, 1);

      // Enable dropped while waiting
      cyc(0, 1, 4'd2, 1, 0, 1, ex(0, 1, 0, 0, cnt), "wait2");
      cyc(0, 0, 4'd2, 1, 0, 1, ex(0, 0, 0, 0, cnt), "wait_abort");

      // Fill entered with the level already high lasts one cycle
      cyc(0, 1, 4'd2, 1, 0, 1, ex(0, 1, 0, 0, cnt), "wait3");
      cyc(0, 1, 4'd14, 0, 0, 1, ex(1, 1, 0, 0, cnt), "fill_at_high");
      cyc(0, 1, 4'd14, 0, 0, 1, ex(0, 1, 0, 0, cnt), "one_cycle_fill");
      settle_out(4'd0, 1);

      // Timeout: valve open exactly 15 cycles, then latched fault
      cyc(0, 1, 4'd2, 0, 0, 1, ex(1, 1, 0, 0, cnt), "to_start");
      for (int i = 1; i <= 14; i++) begin
         cyc(0, 1, 4'd2, 0, 0, 1, ex(1, 1, 4'(i), 0, cnt), "to_run");
      end
      cyc(0, 1, 4'd2, 0, 0, 1, ex(0, 0, 14, 1, cnt), "to_fault");
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 4'd2, 0, 0, 1, ex(0, 0, 14, 1, cnt), "fault_hold");
      end
      cyc(0, 1, 4'd2, 0, 1, 1, ex(0, 0, 14, 0, cnt), "fault_clear");
      cyc(0, 1, 4'd2, 0, 0, 1, ex(1, 1, 0, 0, cnt), "refill_after_clear");

      // Abort in the third filling cycle
      cyc(0, 1, 4'd2, 0, 0, 1, ex(1, 1, 1, 0, cnt), "abort_c2");
      cyc(0, 1, 4'd2, 0, 0, 1, ex(1, 1, 2, 0, cnt), "abort_c3");
      cyc(0, 0, 4'd2, 0, 0, 1, ex(0, 0, 2, 0, cnt), "abort");
      cyc(0, 0, 4'd2, 0, 0, 1, ex(0, 0, 0, 0, cnt), "abort_idle");

      // Reset in the middle of a fill
      cyc(0, 1, 4'd2, 0, 0, 1, ex(1, 1, 0, 0, cnt), "pre_reset_fill");
      cyc(0, 1, 4'd2, 0, 0, 1, ex(1, 1, 1, 0, cnt), "pre_reset_run");
      cnt = 8'd0;
      cyc(1, 1, 4'd2, 0, 0, 1, ex(0, 0, 0, 0, 0), "reset_mid_fill");
      cyc(0, 0, 4'd8, 0, 0, 1, ex(0, 0, 0, 0, 0), "post_reset_idle");

      // Hysteresis band, disabled request, stray fault_clear
      cyc(0, 1, 4'd5, 0, 0, 1, ex(0, 0, 0, 0, cnt), "hyst_5");
      cyc(0, 1, 4'd8, 0, 0, 1, ex(0, 0, 0, 0, cnt), "hyst_8");
      cyc(0, 1, 4'd11, 0, 1, 1, ex(0, 0, 0, 0, cnt), "hyst_11_clear");
      cyc(0, 0, 4'd2, 0, 0, 1, ex(0, 0, 0, 0, cnt), "disabled_low");

      // Preload 255 completed refills at the LOW_MARK boundary, then wrap
      for (int k = 0; k < 255; k++) begin
         cyc(0, 1, 4'd4, 0, 0, 0, ex(0, 0, 0, 0, 0), "");
         cyc(0, 1, 4'd12, 0, 0, 0, ex(0, 0, 0, 0, 0), "");
         settle_out(4'd0, 0);
      end
      cyc(0, 1, 4'd8, 0, 0, 1, ex(0, 0, 0, 0, 8'd255), "count_255");
      cyc(0, 1, 4'd4, 0, 0, 1, ex(1, 1, 0, 0, cnt), "wrap_fill");
      cyc(0, 1, 4'd12, 0, 0, 1, ex(0, 1, 0, 0, cnt), "wrap_settle");
      settle_out(4'd0, 1);
      cyc(0, 1, 4'd8, 0, 0, 1, ex(0, 0, 0, 0, 8'd0), "count_wrapped");

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL drain: %0d expected responses left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
